// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 16x16 signed parity-checked multiplier among
// N_REQ requesters: grant, issue, wait for result, return, with a watchdog abort.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*16-1:0] req_arg_a,
  input  logic [N_REQ-1:0]    req_arg_a_parity,
  input  logic [N_REQ*16-1:0] req_arg_b,
  input  logic [N_REQ-1:0]    req_arg_b_parity,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    res_rdy,
  output logic [31:0]         res_data,
  output logic                res_parity,
  output logic                res_parity_error,
  output logic                res_timeout,
  output logic                m_req,
  output logic [15:0]         m_arg_a,
  output logic [15:0]         m_arg_b,
  output logic                m_arg_a_parity,
  output logic                m_arg_b_parity,
  input  logic                m_ack,
  input  logic [31:0]         m_result,
  input  logic                m_result_parity,
  input  logic                m_result_rdy,
  input  logic                m_arg_parity_error
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, g, g_nx, pick;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          timeout_hit;

  logic [N_REQ-1:0] ack_nx, res_rdy_nx;
  logic [31:0]      res_data_nx;
  logic             res_parity_nx, res_parity_error_nx, res_timeout_nx, m_req_nx;
  logic [15:0]      m_arg_a_nx, m_arg_b_nx;
  logic             m_arg_a_parity_nx, m_arg_b_parity_nx;

  // First set request bit searching from p upward, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0]   c;
    logic [PW-1:0] sel;
    sel = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      c   = {1'b0, p} + (PW+1)'(i);
      c   = (c >= (PW+1)'(N_REQ)) ? c - (PW+1)'(N_REQ) : c;
      sel = r[c[PW-1:0]] ? c[PW-1:0] : sel;
    end
    rr_pick = sel;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign pick        = rr_pick(req, ptr);
  assign cnt_inc     = cnt + 17'd1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx            = state;
    ptr_nx              = ptr;
    g_nx                = g;
    cnt_nx              = cnt;
    ack_nx              = {N_REQ{1'b0}};
    res_rdy_nx          = {N_REQ{1'b0}};
    res_data_nx         = 32'd0;
    res_parity_nx       = 1'b0;
    res_parity_error_nx = 1'b0;
    res_timeout_nx      = 1'b0;
    m_req_nx            = 1'b0;
    m_arg_a_nx          = m_arg_a;
    m_arg_b_nx          = m_arg_b;
    m_arg_a_parity_nx   = m_arg_a_parity;
    m_arg_b_parity_nx   = m_arg_b_parity;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx          = ISSUE;
          g_nx              = pick;
          cnt_nx            = {CW{1'b0}};
          ack_nx            = onehot(pick);
          m_req_nx          = 1'b1;
          m_arg_a_nx        = req_arg_a[{pick, 4'b0000} +: 16];
          m_arg_b_nx        = req_arg_b[{pick, 4'b0000} +: 16];
          m_arg_a_parity_nx = req_arg_a_parity[pick];
          m_arg_b_parity_nx = req_arg_b_parity[pick];
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx = cnt_inc;
        if (timeout_hit) begin
          state_nx       = RESP;
          res_rdy_nx     = onehot(g);
          res_timeout_nx = 1'b1;
        end else if (m_ack) begin
          state_nx = WAIT;
        end else begin
          m_req_nx = 1'b1;
        end
      end
      WAIT: begin
        cnt_nx = cnt_inc;
        // A real result on the watchdog's last cycle still wins over the abort.
        if (m_result_rdy) begin
          state_nx            = RESP;
          res_rdy_nx          = onehot(g);
          res_data_nx         = m_result;
          res_parity_nx       = m_result_parity;
          res_parity_error_nx = m_arg_parity_error;
        end else if (timeout_hit) begin
          state_nx       = RESP;
          res_rdy_nx     = onehot(g);
          res_timeout_nx = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      RESP: begin
        state_nx = IDLE;
        ptr_nx   = (g == PW'(N_REQ - 1)) ? {PW{1'b0}} : g + PW'(1);
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, pointer, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= {PW{1'b0}};
      g                <= {PW{1'b0}};
      cnt              <= {CW{1'b0}};
      ack              <= {N_REQ{1'b0}};
      res_rdy          <= {N_REQ{1'b0}};
      res_data         <= 32'd0;
      res_parity       <= 1'b0;
      res_parity_error <= 1'b0;
      res_timeout      <= 1'b0;
      m_req            <= 1'b0;
      m_arg_a          <= 16'd0;
      m_arg_b          <= 16'd0;
      m_arg_a_parity   <= 1'b0;
      m_arg_b_parity   <= 1'b0;
    end else begin
      state            <= state_nx;
      ptr              <= ptr_nx;
      g                <= g_nx;
      cnt              <= cnt_nx;
      ack              <= ack_nx;
      res_rdy          <= res_rdy_nx;
      res_data         <= res_data_nx;
      res_parity       <= res_parity_nx;
      res_parity_error <= res_parity_error_nx;
      res_timeout      <= res_timeout_nx;
      m_req            <= m_req_nx;
      m_arg_a          <= m_arg_a_nx;
      m_arg_b          <= m_arg_b_nx;
      m_arg_a_parity   <= m_arg_a_parity_nx;
      m_arg_b_parity   <= m_arg_b_parity_nx;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: the bench plays the requesters and the
// multiplier, sampling DUT outputs on the falling edge.
module tb_mult_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*16-1:0] req_arg_a, req_arg_b;
  logic [N-1:0]  req_arg_a_parity, req_arg_b_parity;
  logic [N-1:0]  ack, res_rdy;
  logic [31:0]   res_data;
  logic          res_parity, res_parity_error, res_timeout;
  logic          m_req;
  logic [15:0]   m_arg_a, m_arg_b;
  logic          m_arg_a_parity, m_arg_b_parity;
  logic          m_ack;
  logic [31:0]   m_result;
  logic          m_result_parity, m_result_rdy, m_arg_parity_error;

  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_arg_a(req_arg_a), .req_arg_a_parity(req_arg_a_parity),
    .req_arg_b(req_arg_b), .req_arg_b_parity(req_arg_b_parity),
    .ack(ack), .res_rdy(res_rdy), .res_data(res_data), .res_parity(res_parity),
    .res_parity_error(res_parity_error), .res_timeout(res_timeout),
    .m_req(m_req), .m_arg_a(m_arg_a), .m_arg_b(m_arg_b),
    .m_arg_a_parity(m_arg_a_parity), .m_arg_b_parity(m_arg_b_parity),
    .m_ack(m_ack), .m_result(m_result), .m_result_parity(m_result_parity),
    .m_result_rdy(m_result_rdy), .m_arg_parity_error(m_arg_parity_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_arg_a[16*i +: 16] = a;
    req_arg_b[16*i +: 16] = b;
    req_arg_a_parity[i]   = ^a;
    req_arg_b_parity[i]   = ^b;
  endtask

  // One full transaction: expect grant g, act as a multiplier that acks one
  // cycle after seeing m_req and returns the product a few cycles later.
  task automatic txn(input int g, input logic [31:0] prod, input logic perr,
                     input logic drop, input string tag);
    int          n;
    logic [3:0]  oh;
    logic [31:0] sa, sb, p;
    oh = 4'b0001 << g;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack === 4'b0000 && n < 20);
    chk({tag, ".grant"}, 32'(ack), 32'(oh));
    chk({tag, ".m_req"}, 32'(m_req), 32'(1'b1));
    chk({tag, ".arg_a"}, 32'(m_arg_a), 32'(req_arg_a[16*g +: 16]));
    chk({tag, ".arg_b"}, 32'(m_arg_b), 32'(req_arg_b[16*g +: 16]));
    chk({tag, ".par_a"}, 32'(m_arg_a_parity), 32'(req_arg_a_parity[g]));
    chk({tag, ".par_b"}, 32'(m_arg_b_parity), 32'(req_arg_b_parity[g]));
    if (drop) req = 4'b0000;
    @(negedge clk);
    chk({tag, ".ack_pulse"}, 32'(ack), 32'(4'b0000));
    chk({tag, ".m_req_hold"}, 32'(m_req), 32'(1'b1));
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk({tag, ".m_req_drop"}, 32'(m_req), 32'(1'b0));
    repeat (2) @(negedge clk);
    sa = {{16{m_arg_a[15]}}, m_arg_a};
    sb = {{16{m_arg_b[15]}}, m_arg_b};
    p  = sa * sb;
    m_result           = p;
    m_result_parity    = ^p;
    m_arg_parity_error = perr;
    m_result_rdy       = 1'b1;
    @(negedge clk);
    m_result_rdy       = 1'b0;
    m_result           = 32'd0;
    m_result_parity    = 1'b0;
    m_arg_parity_error = 1'b0;
    chk({tag, ".res_rdy"}, 32'(res_rdy), 32'(oh));
    chk({tag, ".res_data"}, res_data, prod);
    chk({tag, ".res_par"}, 32'(res_parity), 32'(^prod));
    chk({tag, ".res_perr"}, 32'(res_parity_error), 32'(perr));
    chk({tag, ".res_to"}, 32'(res_timeout), 32'(1'b0));
    @(negedge clk);
    chk({tag, ".res_rdy_end"}, 32'(res_rdy), 32'(4'b0000));
    chk({tag, ".res_data_end"}, res_data, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 4'b0000;
    req_arg_a = 64'd0; req_arg_b = 64'd0;
    req_arg_a_parity = 4'b0000; req_arg_b_parity = 4'b0000;
    m_ack = 1'b0; m_result = 32'd0; m_result_parity = 1'b0;
    m_result_rdy = 1'b0; m_arg_parity_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(ack), 32'(4'b0000));
    chk("rst.res_rdy", 32'(res_rdy), 32'(4'b0000));
    chk("rst.m_req", 32'(m_req), 32'(1'b0));
    chk("rst.res_data", res_data, 32'd0);
    chk("rst.m_arg_a", 32'(m_arg_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesting continuously: grants must rotate 0,1,2,3,0.
    set_op(0, 16'sd100, -16'sd3);
    set_op(1, -16'sd7, 16'sd1234);
    set_op(2, 16'sd255, 16'sd256);
    set_op(3, -16'sd1000, -16'sd1000);
    req = 4'b1111;
    txn(0, -32'sd300, 1'b0, 1'b0, "rr0");
    txn(1, -32'sd8638, 1'b0, 1'b0, "rr1");
    txn(2, 32'sd65280, 1'b0, 1'b0, "rr2");
    txn(3, 32'sd1000000, 1'b0, 1'b0, "rr3");
    txn(0, -32'sd300, 1'b0, 1'b0, "rr4");
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Single request, withdrawn after grant; latched operands still used.
    set_op(0, 16'sd3, -16'sd5);
    req = 4'b0001;
    txn(0, -32'sd15, 1'b0, 1'b1, "single");

    set_op(2, 16'h8000, 16'h8000);
    req = 4'b0100;
    txn(2, 32'h40000000, 1'b0, 1'b1, "bnd_minmin");
    set_op(1, 16'h7FFF, 16'h8000);
    req = 4'b0010;
    txn(1, -32'sd1073709056, 1'b0, 1'b1, "bnd_maxmin");

    // Parity error from the multiplier; deliberately wrong A parity passes through.
    set_op(3, 16'sd5, 16'sd6);
    req_arg_a_parity[3] = ~req_arg_a_parity[3];
    req = 4'b1000;
    txn(3, 32'sd30, 1'b1, 1'b1, "perr");

    // Watchdog: multiplier never acks or returns.
    set_op(1, 16'sd77, 16'sd2);
    req = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack === 4'b0000 && n < 20);
    chk("to.grant", 32'(ack), 32'(4'b0010));
    req = 4'b0000;
    m_result = 32'hDEADBEEF; m_result_parity = 1'b1; m_arg_parity_error = 1'b1;
    repeat (9) @(negedge clk);
    chk("to.m_req_late", 32'(m_req), 32'(1'b1));
    chk("to.res_rdy_early", 32'(res_rdy), 32'(4'b0000));
    n = 9;
    do begin
      @(negedge clk);
      n++;
    end while (res_rdy === 4'b0000 && n < 30);
    chk("to.latency", 32'(n), 32'd10);
    chk("to.res_rdy", 32'(res_rdy), 32'(4'b0010));
    chk("to.res_timeout", 32'(res_timeout), 32'(1'b1));
    chk("to.res_data", res_data, 32'd0);
    chk("to.res_par", 32'(res_parity), 32'(1'b0));
    chk("to.res_perr", 32'(res_parity_error), 32'(1'b0));
    chk("to.m_req", 32'(m_req), 32'(1'b0));
    @(negedge clk);
    chk("to.timeout_end", 32'(res_timeout), 32'(1'b0));
    m_result_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("stale.res_rdy", 32'(res_rdy), 32'(4'b0000));
    chk("stale.res_data", res_data, 32'd0);
    m_result_rdy = 1'b0; m_result = 32'd0;
    m_result_parity = 1'b0; m_arg_parity_error = 1'b0;
    @(negedge clk);

    set_op(2, -16'sd2, -16'sd3);
    req = 4'b0100;
    txn(2, 32'sd6, 1'b0, 1'b1, "post_to");

    // Reset while waiting on the multiplier; pointer must restart at 0.
    set_op(3, 16'sd9, 16'sd9);
    req = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack === 4'b0000 && n < 20);
    chk("rstw.grant", 32'(ack), 32'(4'b1000));
    @(negedge clk);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("rstw.in_wait", 32'(m_req), 32'(1'b0));
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    chk("rstw.ack", 32'(ack), 32'(4'b0000));
    chk("rstw.res_rdy", 32'(res_rdy), 32'(4'b0000));
    chk("rstw.m_req", 32'(m_req), 32'(1'b0));
    chk("rstw.res_data", res_data, 32'd0);
    chk("rstw.res_to", 32'(res_timeout), 32'(1'b0));
    chk("rstw.m_arg_a", 32'(m_arg_a), 32'd0);
    rst = 1'b0;
    m_result = 32'd81; m_result_rdy = 1'b1;
    @(negedge clk);
    m_result = 32'd0; m_result_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstw.no_res", 32'(res_rdy), 32'(4'b0000));
    end
    set_op(0, 16'sd11, -16'sd11);
    req = 4'b1001;
    txn(0, -32'sd121, 1'b0, 1'b1, "rstw.rr");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
